// File: rtl/mont_pkg.sv
// ----------------------------------------------------------------------------
// mont_pkg
// Shared types and sizing helpers for the radix-2 Montgomery multiplier.
//   state_e      : controller states
//   calc_nl      : number of LIMB-wide slices covering a (WIDTH+2)-bit value
//   calc_iter_w  : width of the bit-iteration counter (counts 0..WIDTH)
//   calc_limb_w  : width of the limb counter (counts 0..NL)
// ----------------------------------------------------------------------------
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ITER,
        RES,
        SUB,
        FIN,
        ERR
    } state_e;

    // The redundant accumulator is WIDTH+2 bits; the top limb is zero-padded.
    function automatic int calc_nl(input int width, input int limb);
        return (width + 2 + limb - 1) / limb;
    endfunction

    function automatic int calc_iter_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int calc_limb_w(input int nl);
        return $clog2(nl + 1);
    endfunction

endpackage

// File: rtl/mont_mul_rdx2_if.sv
// ----------------------------------------------------------------------------
// mont_mul_rdx2_if
// Request/response bundle of the Montgomery multiplier.
//   start          : one-cycle request (requester -> multiplier)
//   in_a/in_b/in_m : multiplicand, multiplier, modulus (requester -> multiplier)
//   busy/done/err  : status and completion pulse (multiplier -> requester)
//   result         : A*B*2^-WIDTH mod M (multiplier -> requester)
// master = requester side, slave = multiplier side.
// ----------------------------------------------------------------------------
interface mont_mul_rdx2_if #(
    parameter int WIDTH = 1024
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, in_a, in_b, in_m,
        input  busy, done, err, result
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output busy, done, err, result
    );
endinterface

// File: rtl/mont_limb_addsub.sv
// ----------------------------------------------------------------------------
// mont_limb_addsub
// One LIMB-wide adder/subtractor slice used to walk a wide value limb by limb.
//   clk, resetn : clock, synchronous active-low reset
//   i_en        : register the carry/borrow of this slice
//   i_first     : this is the least significant limb (ignore stored carry)
//   i_sub       : 0 = i_a + i_b, 1 = i_a - i_b
//   i_a, i_b    : operand limbs
//   o_y         : result limb (combinational)
//   o_carry     : registered carry out; in subtract mode 1 means "no borrow"
// ----------------------------------------------------------------------------
module mont_limb_addsub #(
    parameter int LIMB = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_en,
    input  logic            i_first,
    input  logic            i_sub,
    input  logic [LIMB-1:0] i_a,
    input  logic [LIMB-1:0] i_b,
    output logic [LIMB-1:0] o_y,
    output logic            o_carry
);
    logic            r_carry;
    logic            w_cin;
    logic [LIMB-1:0] w_b;
    logic [LIMB:0]   w_sum;

    // Subtraction is a + ~b + 1; the first limb supplies the +1, later limbs
    // take the stored carry (inverted borrow) of the previous limb.
    always_comb begin
        w_b   = i_sub ? ~i_b : i_b;
        w_cin = i_first ? i_sub : r_carry;
        w_sum = {1'b0, i_a} + {1'b0, w_b} + {{LIMB{1'b0}}, w_cin};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_carry <= 1'b0;
        end else if (i_en) begin
            r_carry <= w_sum[LIMB];
        end
    end

    assign o_y     = w_sum[LIMB-1:0];
    assign o_carry = r_carry;

endmodule

// File: rtl/mont_mul_rdx2.sv
// ----------------------------------------------------------------------------
// mont_mul_rdx2
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M, fully reduced.
// One multiplier bit per cycle in carry-save form, then limb-serial carry
// resolution, then a limb-serial conditional subtraction of M.
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : request/response bundle (slave side), see mont_mul_rdx2_if
// Latency: done is high in the cycle after edge E(WIDTH + 2*NL + 1), counting
// the accepting edge as E0. An even modulus completes at E1 with err=1.
// ----------------------------------------------------------------------------
module mont_mul_rdx2
    import mont_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int LIMB  = 128
) (
    input  logic             clk,
    input  logic             resetn,
    mont_mul_rdx2_if.slave   bus
);
    localparam int NL = calc_nl(WIDTH, LIMB);
    localparam int PW = NL * LIMB;      // padded width of the limb datapath
    localparam int CW = WIDTH + 2;      // accumulator width, C < 2M
    localparam int EW = WIDTH + 3;      // compressor width, T + q*M < 4M
    localparam int IW = calc_iter_w(WIDTH);
    localparam int LW = calc_limb_w(NL);

    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
    localparam logic [LW-1:0] LIMB_LAST = LW'(NL - 1);

    state_e r_state;
    state_e w_next;

    logic [WIDTH-1:0] r_a;          // shifted right each ITER cycle, a_i = r_a[0]
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_s;          // redundant accumulator: C = r_s + r_k
    logic [CW-1:0]    r_k;
    logic [IW-1:0]    r_i;
    logic [LW-1:0]    r_limb;
    logic [PW-1:0]    r_c;          // resolved C
    logic [PW-1:0]    r_d;          // C - M
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_err;

    // FSM outputs
    logic w_busy;
    logic w_load;
    logic w_as_en;
    logic w_as_sub;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_next = bus.in_m[0] ? ITER : ERR;
            ITER: if (r_i == ITER_LAST) w_next = RES;
            RES:  if (r_limb == LIMB_LAST) w_next = SUB;
            SUB:  if (r_limb == LIMB_LAST) w_next = FIN;
            FIN:  w_next = IDLE;
            ERR:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy   = (r_state != IDLE);
        w_load   = (r_state == IDLE) && bus.start;
        w_as_en  = (r_state == RES) || (r_state == SUB);
        w_as_sub = (r_state == SUB);
    end

    // ------------------------------------------------------------------
    // ITER datapath: two 3:2 compressor levels, no carry propagation.
    //   level 1: S + K + a_i*B      -> s1, c1   (q = LSB of s1, c1[0] = 0)
    //   level 2: s1 + c1 + q*M      -> s2, c2   (s2[0] = c2[0] = 0 for odd M)
    // Halving is then a plain right shift of both rows.
    // ------------------------------------------------------------------
    logic [EW-1:0] w_s_ext, w_k_ext, w_ab, w_qm;
    logic [EW-1:0] w_s1, w_c1, w_s2, w_c2;
    logic          w_q;

    always_comb begin
        w_s_ext = EW'(r_s);
        w_k_ext = EW'(r_k);
        w_ab    = r_a[0] ? EW'(r_b) : '0;
        w_s1    = w_s_ext ^ w_k_ext ^ w_ab;
        w_c1    = ((w_s_ext & w_k_ext) | (w_s_ext & w_ab) | (w_k_ext & w_ab)) << 1;
        w_q     = w_s1[0];
        w_qm    = w_q ? EW'(r_m) : '0;
        w_s2    = w_s1 ^ w_c1 ^ w_qm;
        w_c2    = ((w_s1 & w_c1) | (w_s1 & w_qm) | (w_c1 & w_qm)) << 1;
    end

    // ------------------------------------------------------------------
    // RES/SUB datapath: one shared slice, operand limbs muxed by state.
    //   RES: r_c[j] = S[j] + K[j] + carry
    //   SUB: r_d[j] = r_c[j] - M[j] - borrow
    // ------------------------------------------------------------------
    logic [PW-1:0]   w_s_pad, w_k_pad, w_m_pad;
    logic [LIMB-1:0] w_op_a, w_op_b, w_y;
    logic            w_carry;
    logic            w_first;
    int              w_base;

    always_comb begin
        w_s_pad = PW'(r_s);
        w_k_pad = PW'(r_k);
        w_m_pad = PW'(r_m);
        w_base  = int'(r_limb) * LIMB;
        w_first = (r_limb == '0);
        w_op_a  = w_as_sub ? r_c[w_base +: LIMB]     : w_s_pad[w_base +: LIMB];
        w_op_b  = w_as_sub ? w_m_pad[w_base +: LIMB] : w_k_pad[w_base +: LIMB];
    end

    mont_limb_addsub #(
        .LIMB (LIMB)
    ) u_addsub (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (w_as_en),
        .i_first (w_first),
        .i_sub   (w_as_sub),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_y     (w_y),
        .o_carry (w_carry)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_s      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_limb   <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a    <= bus.in_a;
                r_b    <= bus.in_b;
                r_m    <= bus.in_m;
                r_s    <= '0;
                r_k    <= '0;
                r_i    <= '0;
                r_limb <= '0;
                r_err  <= 1'b0;
            end
            unique case (r_state)
                ITER: begin
                    r_a <= r_a >> 1;
                    r_s <= w_s2[EW-1:1];
                    r_k <= w_c2[EW-1:1];
                    r_i <= r_i + IW'(1);
                end
                RES: begin
                    r_c[w_base +: LIMB] <= w_y;
                    r_limb <= (r_limb == LIMB_LAST) ? '0 : r_limb + LW'(1);
                end
                SUB: begin
                    r_d[w_base +: LIMB] <= w_y;
                    r_limb <= (r_limb == LIMB_LAST) ? '0 : r_limb + LW'(1);
                end
                FIN: begin
                    // Final borrow (carry = 0) means C < M, so keep C.
                    r_result <= w_carry ? r_d[WIDTH-1:0] : r_c[WIDTH-1:0];
                    r_done   <= 1'b1;
                end
                ERR: begin
                    r_result <= '0;
                    r_done   <= 1'b1;
                    r_err    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bits that are structurally zero or never needed for the W-bit result.
    logic w_unused;
    assign w_unused = ^{r_d[PW-1:WIDTH], w_s2[0], w_c2[0]};

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule

// File: tb/tb_mont_mul_rdx2.sv
// ----------------------------------------------------------------------------
// tb_mont_mul_rdx2
// Two instances: WIDTH=8/LIMB=4 for directed and corner scenarios, and
// WIDTH=1024/LIMB=128 for randomized operands. Expected results come from a
// reference that reduces A*B mod M and then halves modulo M WIDTH times.
// ----------------------------------------------------------------------------
module tb_mont_mul_rdx2;

    localparam int SW    = 8;
    localparam int SL    = 4;
    localparam int BW    = 1024;
    localparam int BL    = 128;
    localparam int S_NL  = (SW + 2 + SL - 1) / SL;
    localparam int B_NL  = (BW + 2 + BL - 1) / BL;
    localparam int S_LAT = SW + 2 * S_NL + 1;
    localparam int B_LAT = BW + 2 * B_NL + 1;
    localparam int N_BIG = 30;
    localparam int N_SMALL = 100;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

    mont_mul_rdx2_if #(.WIDTH(SW)) s_if ();
    mont_mul_rdx2_if #(.WIDTH(BW)) l_if ();

    mont_mul_rdx2 #(.WIDTH(SW), .LIMB(SL)) u_small (
        .clk    (clk),
        .resetn (resetn),
        .bus    (s_if.slave)
    );

    mont_mul_rdx2 #(.WIDTH(BW), .LIMB(BL)) u_big (
        .clk    (clk),
        .resetn (resetn),
        .bus    (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [BW-1:0] ref_mont(input logic [BW-1:0] a, b, m, input int w);
        logic [2*BW-1:0] p;
        logic [BW:0]     x;
        p = ((2*BW)'(a) * (2*BW)'(b)) % (2*BW)'(m);
        x = (BW+1)'(p[BW-1:0]);
        for (int i = 0; i < w; i++) begin
            if (x[0]) x = (x + (BW+1)'(m)) >> 1;
            else      x = x >> 1;
        end
        return x[BW-1:0];
    endfunction

    // ---------------- access helpers ----------------
    task automatic drive(input bit big, input logic st, input logic [BW-1:0] a, b, m);
        if (big) begin
            l_if.start = st; l_if.in_a = a; l_if.in_b = b; l_if.in_m = m;
        end else begin
            s_if.start = st; s_if.in_a = a[SW-1:0]; s_if.in_b = b[SW-1:0]; s_if.in_m = m[SW-1:0];
        end
    endtask

    function automatic logic get_busy(input bit big);
        return big ? l_if.busy : s_if.busy;
    endfunction
    function automatic logic get_done(input bit big);
        return big ? l_if.done : s_if.done;
    endfunction
    function automatic logic get_err(input bit big);
        return big ? l_if.err : s_if.err;
    endfunction
    function automatic logic [BW-1:0] get_result(input bit big);
        return big ? l_if.result : BW'(s_if.result);
    endfunction

    // One operation with start as a single-cycle pulse. lat is the edge index
    // (E0 = accepting edge) after which done was seen, -1 if never.
    // hs_ok covers busy high until done, busy low with done, done one cycle.
    task automatic run_op(input bit big, input logic [BW-1:0] a, b, m,
                          output int lat, output logic [BW-1:0] res,
                          output logic e, output bit hs_ok);
        int budget;
        budget = big ? B_LAT + 20 : S_LAT + 20;
        lat = -1; res = '0; e = 1'b0; hs_ok = 1'b1;
        @(negedge clk);
        drive(big, 1'b1, a, b, m);
        @(posedge clk);
        @(negedge clk);
        if (big) l_if.start = 1'b0; else s_if.start = 1'b0;
        for (int n = 1; n <= budget && lat < 0; n++) begin
            if (get_busy(big) !== 1'b1) hs_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (get_done(big) === 1'b1) begin
                lat = n;
                if (get_busy(big) !== 1'b0) hs_ok = 1'b0;
                res = get_result(big);
                e   = get_err(big);
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            if (get_done(big) !== 1'b0) hs_ok = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b1, 5, 7, 13);
        drive(1'b1, 1'b1, 5, 7, 13);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (get_busy(k[0]) !== 1'b0) begin n_fail++; $display("FAIL reset busy[%0d]: got %b want 0", k, get_busy(k[0])); end
            n_tests++;
            if (get_done(k[0]) !== 1'b0) begin n_fail++; $display("FAIL reset done[%0d]: got %b want 0", k, get_done(k[0])); end
            n_tests++;
            if (get_err(k[0]) !== 1'b0) begin n_fail++; $display("FAIL reset err[%0d]: got %b want 0", k, get_err(k[0])); end
            n_tests++;
            if (get_result(k[0]) !== '0) begin n_fail++; $display("FAIL reset result[%0d]: got nonzero want 0", k); end
        end
        drive(1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        int ta[3] = '{5, 12, 0};
        int tb[3] = '{7, 12, 9};
        int te[3] = '{1, 3, 0};
        int lat; logic [BW-1:0] res; logic e; bit hs;
        for (int t = 0; t < 3; t++) begin
            run_op(1'b0, BW'(ta[t]), BW'(tb[t]), BW'(13), lat, res, e, hs);
            n_tests++;
            if (res !== BW'(te[t])) begin n_fail++; $display("FAIL directed[%0d] result: got %0d want %0d", t, res[SW-1:0], te[t]); end
            n_tests++;
            if (lat != S_LAT) begin n_fail++; $display("FAIL directed[%0d] latency: got %0d want %0d", t, lat, S_LAT); end
            n_tests++;
            if (e !== 1'b0) begin n_fail++; $display("FAIL directed[%0d] err: got %b want 0", t, e); end
            n_tests++;
            if (!hs) begin n_fail++; $display("FAIL directed[%0d] busy/done handshake: got bad want ok", t); end
        end
    endtask

    task automatic test_even_modulus();
        int lat; logic [BW-1:0] res; logic e; bit hs;
        run_op(1'b0, 3, 4, 12, lat, res, e, hs);
        n_tests++;
        if (lat != 1) begin n_fail++; $display("FAIL even_m latency: got %0d want 1", lat); end
        n_tests++;
        if (e !== 1'b1) begin n_fail++; $display("FAIL even_m err: got %b want 1", e); end
        n_tests++;
        if (res !== '0) begin n_fail++; $display("FAIL even_m result: got %0d want 0", res[SW-1:0]); end
        n_tests++;
        if (!hs) begin n_fail++; $display("FAIL even_m handshake: got bad want ok"); end
        run_op(1'b0, 5, 7, 13, lat, res, e, hs);
        n_tests++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL even_m err_clear: got %b want 0", e); end
        n_tests++;
        if (res !== BW'(1) || lat != S_LAT) begin
            n_fail++; $display("FAIL even_m recovery: got res=%0d lat=%0d want res=1 lat=%0d", res[SW-1:0], lat, S_LAT);
        end
    endtask

    task automatic test_random_small();
        int lat; logic [BW-1:0] res, exp_r; logic e; bit hs;
        int m, a, b;
        for (int t = 0; t < N_SMALL; t++) begin
            m = $urandom_range(3, 255) | 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            exp_r = ref_mont(BW'(a), BW'(b), BW'(m), SW);
            run_op(1'b0, BW'(a), BW'(b), BW'(m), lat, res, e, hs);
            n_tests++;
            if (res !== exp_r || lat != S_LAT || e !== 1'b0 || !hs) begin
                n_fail++;
                $display("FAIL rand_small[%0d] m=%0d a=%0d b=%0d: got res=%0d lat=%0d err=%b hs=%0d want res=%0d lat=%0d err=0 hs=1",
                         t, m, a, b, res[SW-1:0], lat, e, hs, exp_r[SW-1:0], S_LAT);
            end
        end
    endtask

    task automatic test_random_big();
        int lat; logic [BW-1:0] res, exp_r, m, a, b; logic e; bit hs;
        for (int t = 0; t < N_BIG; t++) begin
            for (int w = 0; w < BW / 32; w++) begin
                m[w*32 +: 32] = $urandom;
                a[w*32 +: 32] = $urandom;
                b[w*32 +: 32] = $urandom;
            end
            if (t[0]) m = m >> $urandom_range(0, 900);
            m[0] = 1'b1;
            if (m < BW'(3)) m = BW'(3);
            a = a % m;
            b = b % m;
            if (t == 0) begin a = m - BW'(1); b = m - BW'(1); end
            if (t == 1) a = '0;
            exp_r = ref_mont(a, b, m, BW);
            run_op(1'b1, a, b, m, lat, res, e, hs);
            n_tests++;
            if (res !== exp_r) begin
                n_fail++;
                $display("FAIL rand_big[%0d] result: got low128=%h want low128=%h", t, res[127:0], exp_r[127:0]);
            end
            n_tests++;
            if (lat != B_LAT || e !== 1'b0 || !hs) begin
                n_fail++;
                $display("FAIL rand_big[%0d] timing: got lat=%0d err=%b hs=%0d want lat=%0d err=0 hs=1", t, lat, e, hs, B_LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // First op: start held high the whole time, operands scrambled.
        @(negedge clk);
        drive(1'b0, 1'b1, 5, 7, 13);
        @(posedge clk);
        @(negedge clk);
        s_if.in_a = 8'($urandom); s_if.in_b = 8'($urandom); s_if.in_m = 8'($urandom);
        lat = -1;
        for (int n = 1; n <= S_LAT + 20 && lat < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_if.done === 1'b1) lat = n;
            else begin
                s_if.in_a = 8'($urandom); s_if.in_b = 8'($urandom); s_if.in_m = 8'($urandom);
            end
        end
        n_tests++;
        if (lat != S_LAT || s_if.result !== 8'd1) begin
            n_fail++; $display("FAIL start_held: got lat=%0d res=%0d want lat=%0d res=1", lat, s_if.result, S_LAT);
        end
        // Start is still high during the done cycle: a new op must begin.
        drive(1'b0, 1'b1, 12, 12, 13);
        @(posedge clk);
        @(negedge clk);
        s_if.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= S_LAT + 20 && lat < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_if.done === 1'b1) begin
                lat = n;
                s_if.start = 1'b0;
            end else begin
                // Stray pulses, including one on the edge that raises done.
                s_if.start = ((n % 7) == 0) || ((n % 5) == 0);
                s_if.in_a = 8'($urandom); s_if.in_b = 8'($urandom); s_if.in_m = 8'($urandom);
            end
        end
        n_tests++;
        if (lat != S_LAT || s_if.result !== 8'd3) begin
            n_fail++; $display("FAIL start_in_done_cycle: got lat=%0d res=%0d want lat=%0d res=3", lat, s_if.result, S_LAT);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
            n_fail++; $display("FAIL start_on_done_edge: got busy=%b done=%b want busy=0 done=0", s_if.busy, s_if.done);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [BW-1:0] res; logic e; bit hs; bit saw_done;
        @(negedge clk);
        drive(1'b0, 1'b1, 12, 12, 13);
        @(posedge clk);
        @(negedge clk);
        s_if.start = 1'b0;
        repeat (SW + 1) @(posedge clk);     // first RES edge
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (s_if.busy !== 1'b0 || s_if.done !== 1'b0 || s_if.err !== 1'b0 || s_if.result !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid: got busy=%b done=%b err=%b res=%0d want all 0",
                               s_if.busy, s_if.done, s_if.err, s_if.result);
        end
        resetn = 1'b1;
        saw_done = 1'b0;
        repeat (S_LAT + 5) begin
            @(posedge clk);
            @(negedge clk);
            if (s_if.done === 1'b1) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL reset_mid abandoned: got done pulse want none"); end
        run_op(1'b0, 5, 7, 13, lat, res, e, hs);
        n_tests++;
        if (res !== BW'(1) || lat != S_LAT || e !== 1'b0 || !hs) begin
            n_fail++; $display("FAIL reset_mid recovery: got res=%0d lat=%0d err=%b want res=1 lat=%0d err=0",
                               res[SW-1:0], lat, e, S_LAT);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed();
        test_even_modulus();
        test_random_small();
        test_back_to_back();
        test_reset_mid_op();
        test_random_big();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
